// File: rtl/div.sv
// Multi-cycle restoring divider for the HI/LO path, signed or unsigned.
// One division is in flight at a time. The result is held until start_i drops.
//   clk, rst      : clock (rising edge) and synchronous active-high reset
//   signed_div_i  : 1 = signed divide, 0 = unsigned divide
//   opdata1_i     : dividend, sampled only when the divider is idle
//   opdata2_i     : divisor, sampled only when the divider is idle
//   start_i       : request, held high until ready_o is seen
//   annul_i       : aborts a division in progress
//   result_o      : {remainder, quotient}, registered
//   ready_o       : result valid, registered
module div #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t                state, state_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [2*DATA_W-1:0]   work, work_n;     // {rem, quo}
   logic [DATA_W-1:0]     b_mag, b_mag_n;
   logic                  sgn, sgn_n;
   logic                  sign_a, sign_a_n;
   logic                  sign_b, sign_b_n;
   logic [2*DATA_W-1:0]   result_n;
   logic                  ready_n;

   // Operand magnitudes used at load time.
   logic [DATA_W-1:0]     a_mag_c, b_in_mag_c;
   // Trial subtraction of the shifted partial remainder.
   logic [DATA_W:0]       diff_c;
   // Final sign-corrected quotient and remainder.
   logic [DATA_W-1:0]     quo_fix_c, rem_fix_c;

   always_comb begin
      a_mag_c    = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
      b_in_mag_c = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + DATA_W'(1)) : opdata2_i;
      diff_c     = work[2*DATA_W-1:DATA_W-1] - {1'b0, b_mag};
      quo_fix_c  = (sgn && (sign_a ^ sign_b)) ? (~work[DATA_W-1:0] + DATA_W'(1))
                                              : work[DATA_W-1:0];
      rem_fix_c  = (sgn && sign_a) ? (~work[2*DATA_W-1:DATA_W] + DATA_W'(1))
                                   : work[2*DATA_W-1:DATA_W];
   end

   // Next-state and register-update logic.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      work_n   = work;
      b_mag_n  = b_mag;
      sgn_n    = sgn;
      sign_a_n = sign_a;
      sign_b_n = sign_b;
      result_n = result_o;
      ready_n  = ready_o;

      case (state)
         FREE: begin
            ready_n  = 1'b0;
            result_n = '0;
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_n = BYZERO;
               end else begin
                  state_n  = ON;
                  sgn_n    = signed_div_i;
                  sign_a_n = opdata1_i[DATA_W-1];
                  sign_b_n = opdata2_i[DATA_W-1];
                  b_mag_n  = b_in_mag_c;
                  work_n   = {{DATA_W{1'b0}}, a_mag_c};
                  cnt_n    = '0;
               end
            end
         end
         BYZERO: begin
            state_n  = END;
            result_n = '0;
            ready_n  = 1'b1;
         end
         ON: begin
            if (annul_i) begin
               state_n  = FREE;
               cnt_n    = '0;
               ready_n  = 1'b0;
               result_n = '0;
            end else if (cnt == CNT_W'(DATA_W)) begin
               // All steps done: publish the sign-corrected result.
               state_n  = END;
               result_n = {rem_fix_c, quo_fix_c};
               ready_n  = 1'b1;
            end else begin
               if (!diff_c[DATA_W])
                  work_n = {diff_c[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
               else
                  work_n = {work[2*DATA_W-2:0], 1'b0};
               cnt_n = cnt + CNT_W'(1);
            end
         end
         END: begin
            ready_n = 1'b1;
            // Annul here behaves like start dropping.
            if (!start_i || annul_i) begin
               state_n  = FREE;
               cnt_n    = '0;
               ready_n  = 1'b0;
               result_n = '0;
            end
         end
         default: state_n = FREE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FREE;
         cnt      <= '0;
         work     <= '0;
         b_mag    <= '0;
         sgn      <= 1'b0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         work     <= work_n;
         b_mag    <= b_mag_n;
         sgn      <= sgn_n;
         sign_a   <= sign_a_n;
         sign_b   <= sign_b_n;
         result_o <= result_n;
         ready_o  <= ready_n;
      end
   end

endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: latency, signed/unsigned results,
// divide by zero, annul, reset in flight, and operand changes mid-division.
module tb_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int passed = 0;
   int total  = 0;

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Raise start and count edges until ready (edge 1 samples start).
   // With scramble set, operands are corrupted right after the load edge.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [63:0] exp_res, input bit scramble);
      int n;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         if (scramble && n == 1) begin
            opdata1_i    = 32'h1234_5678;
            opdata2_i    = 32'h0000_0003;
            signed_div_i = ~sgn;
         end
      end while (!ready_o && n < 100);
      check({tag, " latency"}, 64'(n), 64'(exp_lat));
      check({tag, " result"}, result_o, exp_res);
   endtask

   task automatic drop_start(input string tag);
      start_i = 1'b0;
      tick();
      check({tag, " ready cleared"}, 64'(ready_o), 64'd0);
      check({tag, " result cleared"}, result_o, 64'd0);
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
      signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
      tick(); tick();
      check("reset ready", 64'(ready_o), 64'd0);
      check("reset result", result_o, 64'd0);
      rst = 1'b0;
      tick();

      // Unsigned 7/2 and the END hold behaviour.
      run_div("u7/2", 1'b0, 32'd7, 32'd2, 34, 64'h00000001_00000003, 1'b0);
      tick();
      check("u7/2 held ready", 64'(ready_o), 64'd1);
      check("u7/2 held result", result_o, 64'h00000001_00000003);
      drop_start("u7/2");

      run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
      drop_start("s-7/2");
      run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 64'h00000001_FFFFFFFD, 1'b0);
      drop_start("s7/-2");
      run_div("uFFF9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 34, 64'h00000001_7FFFFFFC, 1'b0);
      drop_start("uFFF9/2");
      run_div("uMAX/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34, 64'h00000000_FFFFFFFF, 1'b0);
      drop_start("uMAX/1");
      run_div("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 64'h00000000_80000000, 1'b0);
      drop_start("s ovf");

      // Divide by zero.
      run_div("u/0", 1'b0, 32'd55, 32'd0, 2, 64'd0, 1'b0);
      check("u/0 ready", 64'(ready_o), 64'd1);
      drop_start("u/0");
      run_div("s/0", 1'b1, 32'hFFFF_FFF0, 32'd0, 2, 64'd0, 1'b0);
      drop_start("s/0");

      // Annul partway through the steps; ready must never rise.
      begin
         bit seen_ready;
         seen_ready   = 1'b0;
         signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
         start_i      = 1'b1;
         for (int i = 0; i < 11; i++) begin
            tick();
            if (ready_o) seen_ready = 1'b1;
         end
         annul_i = 1'b1; start_i = 1'b0;
         tick();
         annul_i = 1'b0;
         check("annul ready", 64'(ready_o), 64'd0);
         check("annul result", result_o, 64'd0);
         for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) seen_ready = 1'b1;
         end
         check("annul never ready", 64'(seen_ready), 64'd0);
      end
      run_div("u100/7", 1'b0, 32'd100, 32'd7, 34, 64'h00000002_0000000E, 1'b0);
      drop_start("u100/7");

      // Reset in the middle of a division.
      signed_div_i = 1'b0; opdata1_i = 32'd7; opdata2_i = 32'd2; start_i = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      start_i = 1'b0; rst = 1'b1;
      tick();
      check("rst ON ready", 64'(ready_o), 64'd0);
      check("rst ON result", result_o, 64'd0);
      rst = 1'b0;
      tick();
      check("rst ON idle ready", 64'(ready_o), 64'd0);

      // Reset in END with start held; afterwards a full-latency division
      // with operands disturbed mid-flight must still be correct.
      run_div("pre-rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 34, 64'hFFFFFFFE_FFFFFFF2, 1'b0);
      rst = 1'b1;
      tick();
      check("rst END ready", 64'(ready_o), 64'd0);
      check("rst END result", result_o, 64'd0);
      rst = 1'b0;
      run_div("post-rst", 1'b0, 32'd100, 32'd7, 34, 64'h00000002_0000000E, 1'b1);
      drop_start("post-rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Global time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
